i2si_fifo: RTL and testbench

- Receive-side sample FIFO between the I2S input deserializer (write side) and the register/DMA read port (read side).
- Buffers audio samples and reports fill level.
- Maintains a sticky overrun flag and a saturating dropped-sample counter.
- Both are cleared by the single-cycle trig_i2si_fifo_overrun_clr pulse from trig_generator.

---
 rtl/i2si_fifo_if.sv | 50 +++++
 rtl/i2si_fifo.sv | 116 +++++++++++
 tb/tb_i2si_fifo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/i2si_fifo_if.sv
// Bus bundle between the I2S receive FIFO, its deserializer producer and the register/DMA consumer.
// slave is the FIFO side; master is whoever drives writes, reads and the control strobes.
interface i2si_fifo_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 8
);
    logic              fifo_en;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   fifo_count;
    logic              overrun;
    logic [CNT_W-1:0]  overrun_cnt;
    logic              trig_i2si_fifo_overrun_clr;

    modport master (
        output fifo_en,
        output wr_valid,
        output wr_data,
        output rd_req,
        output trig_i2si_fifo_overrun_clr,
        input  rd_data,
        input  rd_valid,
        input  empty,
        input  full,
        input  fifo_count,
        input  overrun,
        input  overrun_cnt
    );

    modport slave (
        input  fifo_en,
        input  wr_valid,
        input  wr_data,
        input  rd_req,
        input  trig_i2si_fifo_overrun_clr,
        output rd_data,
        output rd_valid,
        output empty,
        output full,
        output fifo_count,
        output overrun,
        output overrun_cnt
    );
endinterface

// File: rtl/i2si_fifo.sv
// I2S receive sample FIFO: circular buffer with registered status, sticky overrun flag
// and a saturating dropped-sample counter.
module i2si_fifo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    i2si_fifo_if.slave  bus
);
    localparam int unsigned   Depth   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(Depth);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [DATA_W-1:0] mem [Depth];

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  overrun_cnt_q, overrun_cnt_d;

    logic rd_acc;
    logic wr_acc;
    logic wr_drop;

    always_comb begin
        rd_acc  = bus.fifo_en & bus.rd_req & ~empty_q;
        // A read on a full FIFO frees the slot the concurrent write lands in.
        wr_acc  = bus.fifo_en & bus.wr_valid & (~full_q | rd_acc);
        wr_drop = bus.fifo_en & bus.wr_valid & full_q & ~rd_acc;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_acc;
        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;

        if (!bus.fifo_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
            end
            count_d = count_q + (ADDR_W + 1)'(wr_acc) - (ADDR_W + 1)'(rd_acc);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == FullCnt);

        // A drop in the same cycle as the clear restarts the count at one.
        if (wr_drop) begin
            overrun_d = 1'b1;
            if (bus.trig_i2si_fifo_overrun_clr) begin
                overrun_cnt_d = CNT_W'(1);
            end else if (overrun_cnt_q != CntMax) begin
                overrun_cnt_d = overrun_cnt_q + 1'b1;
            end
        end else if (bus.trig_i2si_fifo_overrun_clr) begin
            overrun_d     = 1'b0;
            overrun_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    // Sample storage carries no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.fifo_count  = count_q;
    assign bus.overrun     = overrun_q;
    assign bus.overrun_cnt = overrun_cnt_q;
endmodule

// File: tb/tb_i2si_fifo.sv
// Directed bench for i2si_fifo: a table of per-cycle vectors plus hand-written
// sequences for saturation, pointer wrap and asynchronous reset.
module tb_i2si_fifo;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    i2si_fifo_if bus ();

    i2si_fifo u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wv;
        logic [23:0] wd;
        logic        rr;
        logic        clr;
        logic        rv;
        logic [23:0] rd;
        int          cnt;
        logic        o;
        int          oc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic wv, input logic [23:0] wd, input logic rr,
                       input logic clr, input logic rv, input logic [23:0] rd, input int cnt,
                       input logic o, input int oc);
        vec_t v;
        v.en = en; v.wv = wv; v.wd = wd; v.rr = rr; v.clr = clr;
        v.rv = rv; v.rd = rd; v.cnt = cnt; v.o = o; v.oc = oc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rv, input logic [23:0] rd,
                           input int cnt, input logic o, input int oc);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(rv));
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(rd));
        chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(cnt));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(cnt == 8));
        chk({tag, ".overrun"}, 32'(bus.overrun), 32'(o));
        chk({tag, ".overrun_cnt"}, 32'(bus.overrun_cnt), 32'(oc));
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic en, input logic wv, input logic [23:0] wd, input logic rr,
                        input logic clr);
        bus.fifo_en  = en;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_req   = rr;
        bus.trig_i2si_fifo_overrun_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.fifo_en  = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.trig_i2si_fifo_overrun_clr = 1'b0;

        // Test 1: three writes, three spaced single reads, then a read on empty.
        for (int i = 0; i < 3; i++) add(1, 1, 24'(i + 1), 0, 0, 0, 0, i + 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 24'h1, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0, 24'h1, 2, 0, 0);
        add(1, 0, 0, 1, 0, 1, 24'h2, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 24'h2, 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 24'h3, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 24'h3, 0, 0, 0);
        // Test 2: fill, three drops, drain.
        for (int i = 0; i < 8; i++) add(1, 1, 24'(16 + i), 0, 0, 0, 24'h3, i + 1, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 24'(224 + i), 0, 0, 0, 24'h3, 8, 1, i + 1);
        for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, 1, 24'(16 + i), 7 - i, 1, 3);
        // Test 3: write+read on full is accepted without overrun.
        for (int i = 0; i < 8; i++) add(1, 1, 24'(32 + i), 0, 0, 0, 24'h17, i + 1, 1, 3);
        add(1, 1, 24'hABCDEF, 1, 0, 1, 24'h20, 8, 1, 3);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 1, 0, 1, 24'(33 + i), 7 - i, 1, 3);
        add(1, 0, 0, 1, 0, 1, 24'hABCDEF, 0, 1, 3);
        // Test 4: count to 5, clear, then drop coinciding with clear.
        for (int i = 0; i < 8; i++) add(1, 1, 24'(48 + i), 0, 0, 0, 24'hABCDEF, i + 1, 1, 3);
        add(1, 1, 24'hF0, 0, 0, 0, 24'hABCDEF, 8, 1, 4);
        add(1, 1, 24'hF1, 0, 0, 0, 24'hABCDEF, 8, 1, 5);
        add(1, 0, 0, 0, 1, 0, 24'hABCDEF, 8, 0, 0);
        add(1, 1, 24'hF2, 0, 1, 0, 24'hABCDEF, 8, 1, 1);
        for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, 1, 24'(48 + i), 7 - i, 1, 1);
        // Test 6: flush with four entries keeps overrun; clear still works while disabled.
        for (int i = 0; i < 4; i++) add(1, 1, 24'(64 + i), 0, 0, 0, 24'h37, i + 1, 1, 1);
        add(0, 1, 24'h44, 1, 0, 0, 24'h37, 0, 1, 1);
        add(1, 0, 0, 1, 0, 0, 24'h37, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 24'h37, 0, 0, 0);
        // Write+read on empty: only the write lands, no bypass.
        add(1, 1, 24'h55, 1, 0, 0, 24'h37, 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 24'h55, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rd, vecs[i].cnt, vecs[i].o,
                    vecs[i].oc);
        end

        // Saturation: 300 drops on a full FIFO.
        for (int i = 0; i < 8; i++) step(1, 1, 24'(96 + i), 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 24'hBAD, 0, 0);
            if (i == 253) chk("sat_254", 32'(bus.overrun_cnt), 32'hFE);
            if (i == 254) chk("sat_255", 32'(bus.overrun_cnt), 32'hFF);
        end
        chk_all("sat_300", 0, 24'h55, 8, 1, 255);
        step(1, 0, 0, 0, 1);
        chk_all("sat_clr", 0, 24'h55, 8, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1, 0);
            chk_all($sformatf("sat_drain%0d", i), 1, 24'(96 + i), 7 - i, 0, 0);
        end

        // Wrap: five preloaded entries then 20 simultaneous write/read pairs.
        for (int i = 0; i < 5; i++) step(1, 1, 24'(256 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 24'(261 + i), 1, 0);
            chk_all($sformatf("wrap%0d", i), 1, 24'(256 + i), 5, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 0);
            chk_all($sformatf("wrap_drain%0d", i), 1, 24'(276 + i), 4 - i, 0, 0);
        end

        // Asynchronous reset with two entries, a pending read result and a set overrun.
        for (int i = 0; i < 8; i++) step(1, 1, 24'(112 + i), 0, 0);
        step(1, 1, 24'h7F, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0);
        chk_all("pre_rst", 1, 24'h75, 2, 1, 1);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 24'h99, 0, 0);
        chk_all("post_rst_wr", 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        chk_all("post_rst_rd", 1, 24'h99, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
